ddr_stream_writer: RTL

DDR_STREAM_WRITER -- requirements
Module: ddr_stream_writer

---
 rtl/ddr_stream_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/ddr_stream_writer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ddr_stream_pkg.sv
// ddr_stream_pkg
//   Shared definitions for the DDR stream writer: the write FSM state
//   encoding, the bytes-per-word constant and the ring-pointer helper.
package ddr_stream_pkg;

  // Each source word is 32 bits wide, so every beat moves four bytes.
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_START    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_WAIT_FIN = 3'd4
  } wr_state_t;

  // Moves the ring pointer on by one burst. When the next burst would
  // begin exactly at the end of the ring, the pointer wraps to the base.
  function automatic logic [31:0] ring_advance(input logic [31:0] ptr,
                                               input logic [31:0] step,
                                               input logic [31:0] base,
                                               input logic [31:0] ring_bytes);
    logic [31:0] next_ptr;
    next_ptr = ptr + step;
    if (next_ptr == base + ring_bytes) begin
      next_ptr = base;
    end
    return next_ptr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The word at the head is
//   always present on pop_data whenever empty is low, so a pop consumes
//   the word that is visible in the same cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write request; ignored while full
//   push_data  in   WIDTH-bit word to write
//   pop        in   read request; ignored while empty
//   pop_data   out  head word (first-word-fall-through)
//   full       out  no free entries
//   empty      out  no stored entries
//   level      out  number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping. The explicit wrap keeps the FIFO
  // correct for depths that are not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_stream_writer.sv
// ddr_stream_writer
//   Buffers a 32-bit source stream and writes it into a DDR ring buffer
//   as fixed-size bursts through the PS write command interface.
//
// Ports
//   clk_ps            in   sole clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   enable            in   level; high permits new bursts
//   src_valid         in   source word valid
//   src_data          in   source word (32)
//   src_ready         out  input buffer can accept a word
//   ps_ddr_busy       in   high = command path ready for a command
//   ps_ddr_wr_start   out  one-cycle command pulse
//   ps_ddr_wr_addr    out  burst byte address (32), valid with start
//   ps_ddr_wr_length  out  burst length in bytes (32), valid with start
//   ps_ddr_wr_en      out  data beat strobe
//   ps_ddr_wr_data    out  data word (32), valid with wr_en
//   ps_ddr_wr_finish  in   one-cycle pulse marking the end of the burst
//   burst_cnt         out  completed bursts (32), wraps
//   stall_seen        out  sticky: source offered a word while not ready
module ddr_stream_writer
  import ddr_stream_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned BURST_WORDS = 256,
  parameter logic [31:0] RING_BYTES  = 32'h0010_0000,
  parameter int unsigned FIFO_DEPTH  = 1024
) (
  input  logic        clk_ps,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  input  logic        ps_ddr_busy,
  output logic        ps_ddr_wr_start,
  output logic [31:0] ps_ddr_wr_addr,
  output logic [31:0] ps_ddr_wr_length,
  output logic        ps_ddr_wr_en,
  output logic [31:0] ps_ddr_wr_data,
  input  logic        ps_ddr_wr_finish,
  output logic [31:0] burst_cnt,
  output logic        stall_seen
);

  localparam int          LEVEL_W     = $clog2(FIFO_DEPTH + 1);
  localparam int          BEAT_W      = $clog2(BURST_WORDS);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * BYTES_PER_WORD);
  localparam logic [LEVEL_W-1:0] BURST_LEVEL = LEVEL_W'(BURST_WORDS);
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_WORDS - 1);

  wr_state_t          state;
  logic               wr_start_q;
  logic               wr_en_q;
  logic [31:0]        addr_q;
  logic [31:0]        len_q;
  logic [31:0]        ring_ptr;
  logic [31:0]        burst_cnt_q;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               fin_seen;
  logic               stall_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic [31:0]        fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  assign src_ready = !fifo_full;
  assign fifo_push = src_valid && src_ready;
  // Every STREAM beat consumes the head word that is driven out with it.
  assign fifo_pop  = wr_en_q && !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_ps),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (src_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ps_ddr_wr_start  = wr_start_q;
  assign ps_ddr_wr_en     = wr_en_q;
  assign ps_ddr_wr_addr   = addr_q;
  assign ps_ddr_wr_length = len_q;
  // The FIFO storage is not reset, so the data bus is forced to zero
  // outside of beats rather than exposing stale memory contents.
  assign ps_ddr_wr_data   = wr_en_q ? fifo_head : 32'h0;
  assign burst_cnt        = burst_cnt_q;
  assign stall_seen       = stall_q;

  // Sticky flag for a source that offered data while the buffer was full.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else if (src_valid && !src_ready) begin
      stall_q <= 1'b1;
    end
  end

  // Burst sequencer. A burst is only launched once a whole burst worth of
  // words is buffered, so STREAM never has to wait on the source. Once
  // START is reached the burst runs to completion regardless of enable.
  // A finish pulse seen while streaming is remembered in fin_seen so that
  // one landing on the last beat is not lost on the way into WAIT_FIN.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_start_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= 32'h0;
      len_q       <= 32'h0;
      ring_ptr    <= BASE_ADDR;
      burst_cnt_q <= 32'h0;
      beat_cnt    <= '0;
      fin_seen    <= 1'b0;
    end else begin
      wr_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (fifo_level >= BURST_LEVEL)) begin
            state <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (ps_ddr_busy) begin
            state      <= ST_START;
            wr_start_q <= 1'b1;
            addr_q     <= ring_ptr;
            len_q      <= BURST_BYTES;
          end
        end
        ST_START: begin
          state    <= ST_STREAM;
          wr_en_q  <= 1'b1;
          beat_cnt <= '0;
          fin_seen <= 1'b0;
        end
        ST_STREAM: begin
          if (ps_ddr_wr_finish) begin
            fin_seen <= 1'b1;
          end
          if (beat_cnt == LAST_BEAT) begin
            wr_en_q <= 1'b0;
            state   <= ST_WAIT_FIN;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_WAIT_FIN: begin
          if (ps_ddr_wr_finish || fin_seen) begin
            state       <= ST_IDLE;
            fin_seen    <= 1'b0;
            ring_ptr    <= ring_advance(ring_ptr, BURST_BYTES, BASE_ADDR, RING_BYTES);
            burst_cnt_q <= burst_cnt_q + 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
